rng_range_sampler: RTL and testbench

Rejection-sampling front end for `random_num_gen`. It requests NBITS-wide random words over the generator's `enable_p`/`done_p`/`y` handshake and discards words outside the range 1 ≤ y < modulus. It returns the first accepted word, or flags failure after a retry limit or a generator timeout. It feeds the Paillier/encryption datapath, which needs r in Z*_N-range randoms.

---
 rtl/rng_range_sampler.sv | 82 ++++++++
 tb/tb_rng_range_sampler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rng_range_sampler.sv
// rng_range_sampler: rejection sampler that draws random words until one lies in [1, modulus).
module rng_range_sampler #(
  parameter int NBITS   = 2048,
  parameter int MAX_TRY = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] modulus,
  input  logic [11:0]      maxbits_in,
  output logic             rng_enable_p,
  output logic [11:0]      rng_maxbits,
  input  logic             rng_done_p,
  input  logic [NBITS-1:0] rng_y,
  output logic             busy,
  output logic             done_p,
  output logic             fail,
  output logic             timeout,
  output logic [NBITS-1:0] rnd,
  output logic [7:0]       tries
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, DONE} state_t;
  state_t state, state_d;
  logic [NBITS-1:0] mod_q, cand_q;
  logic [19:0] cnt;
  logic start_ok, accept, expire, last_try;
  assign start_ok = state == IDLE && start_p;
  assign accept   = cand_q != '0 && cand_q < mod_q;
  assign expire   = cnt == 20'(TIMEOUT);
  assign last_try = tries >= 8'(MAX_TRY);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start_p ? (modulus == '0 ? DONE : REQ) : IDLE;
      REQ:     state_d = WAIT;
      WAIT:    state_d = rng_done_p ? CHECK : (expire ? DONE : WAIT);
      CHECK:   state_d = (accept || last_try) ? DONE : REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rng_enable_p <= 1'b0;
      done_p       <= 1'b0;
      busy         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      rnd          <= '0;
      tries        <= '0;
      rng_maxbits  <= '0;
      mod_q        <= '0;
      cand_q       <= '0;
      cnt          <= '0;
    end else begin
      rng_enable_p <= state_d == REQ;
      done_p       <= state_d == DONE;
      busy         <= state_d != IDLE;
      tries        <= (start_ok ? 8'd0 : tries) + 8'(state_d == REQ);
      if (start_ok) begin
        mod_q       <= modulus;
        rng_maxbits <= maxbits_in;
        rnd         <= '0;
        fail        <= modulus == '0;
        timeout     <= 1'b0;
      end
      if (state == REQ) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 20'd1;
      if (state == WAIT && rng_done_p) cand_q <= rng_y;
      if (state == WAIT && !rng_done_p && expire) begin
        fail    <= 1'b1;
        timeout <= 1'b1;
      end
      if (state == CHECK && accept) rnd <= cand_q;
      if (state == CHECK && !accept && last_try) fail <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rng_range_sampler.sv
// tb_rng_range_sampler: table-driven bench with a generator model and an expected-result queue.
module tb_rng_range_sampler;
  localparam int NB = 16, MT = 4, TO = 8;
  logic clk = 0, rst_n = 0, start_p = 0, rng_done_p = 0;
  logic [NB-1:0] modulus = '0, rng_y = '0;
  logic [11:0] maxbits_in = '0;
  logic rng_enable_p, busy, done_p, fail, timeout;
  logic [11:0] rng_maxbits;
  logic [NB-1:0] rnd;
  logic [7:0] tries;
  int checks = 0, errors = 0;

  rng_range_sampler #(.NBITS(NB), .MAX_TRY(MT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .modulus(modulus), .maxbits_in(maxbits_in),
    .rng_enable_p(rng_enable_p), .rng_maxbits(rng_maxbits), .rng_done_p(rng_done_p), .rng_y(rng_y),
    .busy(busy), .done_p(done_p), .fail(fail), .timeout(timeout), .rnd(rnd), .tries(tries)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]       m;
    logic [3:0][15:0]  w;
    int                lat;
    bit                noise;
    logic [15:0]       rnd;
    bit                fail;
    bit                to;
    int                tries;
  } vec_t;
  typedef struct {
    logic [15:0] rnd;
    bit          fail;
    bit          to;
    int          tries;
  } exp_t;
  exp_t exp_q[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_enable"}, 32'(rng_enable_p), 0);
    chk({tag, "_done"}, 32'(done_p), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_rnd"}, 32'(rnd), 0);
    chk({tag, "_tries"}, 32'(tries), 0);
    chk({tag, "_maxbits"}, 32'(rng_maxbits), 0);
  endtask

  // lat = cycles from rng_enable_p to the generator's rng_done_p; 0 means the generator never answers.
  task automatic run_op(input vec_t v, input int id);
    logic [11:0] mb;
    exp_t e;
    int n_en, idx, cd, last_en, exp_c;
    bit got;
    mb = 12'(id * 37 + 5);
    exp_q.push_back('{v.rnd, v.fail, v.to, v.tries});
    @(negedge clk);
    start_p = 1; modulus = v.m; maxbits_in = mb;
    @(negedge clk);
    start_p = v.noise; modulus = '0; maxbits_in = ~mb;
    n_en = 0; idx = 0; cd = 0; last_en = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      rng_done_p = 0;
      if (done_p) begin
        got = 1;
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL op%0d_queue: got done_p expected none pending", id);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("op%0d_rnd", id), 32'(rnd), 32'(e.rnd));
          chk($sformatf("op%0d_fail", id), 32'(fail), 32'(e.fail));
          chk($sformatf("op%0d_timeout", id), 32'(timeout), 32'(e.to));
          chk($sformatf("op%0d_tries", id), 32'(tries), 32'(e.tries));
          chk($sformatf("op%0d_enables", id), 32'(n_en), 32'(e.tries));
        end
        chk($sformatf("op%0d_busy", id), 32'(busy), 1);
        chk($sformatf("op%0d_maxbits", id), 32'(rng_maxbits), 32'(mb));
        exp_c = v.m == 0 ? 0 : last_en + (v.to ? TO + 2 : v.lat + 2);
        chk($sformatf("op%0d_latency", id), 32'(c), 32'(exp_c));
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            rng_done_p = 1;
            rng_y = v.w[idx < 4 ? idx : 3];
            idx++;
          end
        end
        if (rng_enable_p) begin
          n_en++;
          last_en = c;
          cd = v.lat;
        end
      end
      @(negedge clk);
    end
    rng_done_p = 0; start_p = 0;
    if (!got) begin
      errors++; checks++;
      $display("FAIL op%0d_done: got no done_p expected done_p within 100 cycles", id);
    end
    chk($sformatf("op%0d_idle_busy", id), 32'(busy), 0);
    chk($sformatf("op%0d_idle_done", id), 32'(done_p), 0);
  endtask

  initial begin
    vecs[0] = '{16'h1000, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0ABC}, 1, 0, 16'h0ABC, 0, 0, 1};
    vecs[1] = '{16'h1000, {16'h0FFF, 16'hFFFF, 16'h1000, 16'h0000}, 1, 1, 16'h0FFF, 0, 0, 4};
    vecs[2] = '{16'h1000, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 2, 0, 16'h0000, 1, 0, 4};
    vecs[3] = '{16'h1000, {16'h0123, 16'h0123, 16'h0123, 16'h0123}, 0, 0, 16'h0000, 1, 1, 1};
    vecs[4] = '{16'h1000, {16'h0123, 16'h0123, 16'h0123, 16'h0123}, TO + 1, 0, 16'h0123, 0, 0, 1};
    vecs[5] = '{16'h1000, {16'h0123, 16'h0123, 16'h0123, 16'h0123}, TO + 2, 0, 16'h0000, 1, 1, 1};
    vecs[6] = '{16'h0000, {16'h0005, 16'h0005, 16'h0005, 16'h0005}, 1, 1, 16'h0000, 1, 0, 0};
    vecs[7] = '{16'hFFFF, {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE}, 3, 0, 16'hFFFE, 0, 0, 1};
    vecs[8] = '{16'h0001, {16'h8000, 16'h0002, 16'h0001, 16'h0000}, 1, 0, 16'h0000, 1, 0, 4};
    vecs[9] = '{16'h0002, {16'h0001, 16'h0001, 16'h0001, 16'h0001}, 1, 0, 16'h0001, 0, 0, 1};

    #1 check_reset_values("por");
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], i);

    // Stray generator pulse while idle must not disturb the held result.
    rng_done_p = 1; rng_y = 16'h0005;
    @(negedge clk);
    rng_done_p = 0;
    @(negedge clk);
    chk("stray_rnd", 32'(rnd), 32'(vecs[9].rnd));
    chk("stray_busy", 32'(busy), 0);
    chk("stray_done", 32'(done_p), 0);
    chk("stray_enable", 32'(rng_enable_p), 0);

    // Asynchronous reset while waiting on the generator, then a late response.
    start_p = 1; modulus = 16'h1000; maxbits_in = 12'h123;
    @(negedge clk);
    start_p = 0;
    chk("rst_enable_c1", 32'(rng_enable_p), 1);
    @(negedge clk);
    chk("rst_busy_wait", 32'(busy), 1);
    rst_n = 0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1; rng_done_p = 1; rng_y = 16'h0ABC;
    @(negedge clk);
    rng_done_p = 0;
    @(negedge clk);
    chk("late_done", 32'(done_p), 0);
    chk("late_busy", 32'(busy), 0);
    chk("late_rnd", 32'(rnd), 0);
    run_op(vecs[0], 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
